// File: rtl/prog_mem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prog_mem_loader_pkg
// Description : Shared state encodings and default word/address widths for
//               the program loader, the computer and the sram.
// Revision    : 1.0 - initial release
// ============================================================================
package prog_mem_loader_pkg;

  // Default word and address widths (2048 x 32 instruction store)
  localparam int c_DEF_DATA_WIDTH = 32;
  localparam int c_DEF_ADDR_WIDTH = 11;

  // Loader controller states, 2-bit encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

endpackage : prog_mem_loader_pkg
`default_nettype wire

// File: rtl/prog_mem_array.sv
`default_nettype none
// ============================================================================
// Module      : prog_mem_array
// Description : Instruction storage with one write port and one registered
//               read port. Storage carries no reset so it maps to block RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_mem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int c_DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [0:c_DEPTH-1];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Write port and registered read port; read data holds while i_re is low
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule : prog_mem_array
`default_nettype wire

// File: rtl/prog_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_mem_loader
// Description : Streams a program into the instruction store over a
//               valid/ready handshake, then releases the CPU and serves
//               registered, bounds-checked instruction fetches. Reports the
//               word count, a running checksum and an overflow error.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_mem_loader
  import prog_mem_loader_pkg::*;
#(
  parameter int DATA_WIDTH = c_DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = c_DEF_ADDR_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_load_start,
  input  logic                  i_load_valid,
  input  logic [DATA_WIDTH-1:0] i_load_data,
  input  logic                  i_load_last,
  output logic                  o_load_ready,
  input  logic                  i_fetch_en,
  input  logic [ADDR_WIDTH-1:0] i_fetch_addr,
  output logic [DATA_WIDTH-1:0] o_fetch_data,
  output logic                  o_fetch_valid,
  output logic                  o_fetch_fault,
  output logic                  o_cpu_run,
  output logic [ADDR_WIDTH:0]   o_load_count,
  output logic [DATA_WIDTH-1:0] o_checksum,
  output logic                  o_load_error
);

  // Highest word address; accepting here without load_last overflows
  localparam logic [ADDR_WIDTH:0] c_LAST_ADDR = {1'b0, {ADDR_WIDTH{1'b1}}};

  state_t                r_state;
  logic                  r_load_ready;
  logic                  r_cpu_run;
  logic [ADDR_WIDTH:0]   r_load_count;
  logic [DATA_WIDTH-1:0] r_checksum;
  logic                  r_load_error;
  logic                  r_fetch_valid;
  logic                  r_fetch_fault;
  logic                  r_fetch_from_mem;

  logic                  w_accept;
  logic                  w_fetch;
  logic                  w_fetch_hit;
  logic [DATA_WIDTH-1:0] w_rdata;

  // A word is taken only while loading and advertising ready
  assign w_accept    = (r_state == ST_LOAD) && i_load_valid && r_load_ready;
  // Fetches are only honoured in RUN, including the cycle load_start arrives
  assign w_fetch     = (r_state == ST_RUN) && i_fetch_en;
  // Only addresses below the loaded word count are reachable
  assign w_fetch_hit = ({1'b0, i_fetch_addr} < r_load_count);

  prog_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (w_accept),
    .i_waddr (r_load_count[ADDR_WIDTH-1:0]),
    .i_wdata (i_load_data),
    .i_re    (w_fetch && w_fetch_hit),
    .i_raddr (i_fetch_addr),
    .o_rdata (w_rdata)
  );

  // Load/run controller with counters, checksum and error flag
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_load_ready <= 1'b0;
      r_cpu_run    <= 1'b0;
      r_load_count <= '0;
      r_checksum   <= '0;
      r_load_error <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_load_start) begin
            r_state      <= ST_LOAD;
            r_load_ready <= 1'b1;
            r_load_count <= '0;
            r_checksum   <= '0;
            r_load_error <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (w_accept) begin
            r_load_count <= r_load_count + 1'b1;
            r_checksum   <= r_checksum + i_load_data;
            if (i_load_last) begin
              r_state      <= ST_RUN;
              r_load_ready <= 1'b0;
              r_cpu_run    <= 1'b1;
            end else if (r_load_count == c_LAST_ADDR) begin
              // Memory full without a last marker: flag it and run anyway
              r_state      <= ST_RUN;
              r_load_ready <= 1'b0;
              r_cpu_run    <= 1'b1;
              r_load_error <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (i_load_start) begin
            r_state      <= ST_LOAD;
            r_load_ready <= 1'b1;
            r_cpu_run    <= 1'b0;
            r_load_count <= '0;
            r_checksum   <= '0;
            r_load_error <= 1'b0;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_load_ready <= 1'b0;
          r_cpu_run    <= 1'b0;
        end
      endcase
    end
  end

  // Fetch response flags; data source selects RAM read or forced zero
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_fetch_valid    <= 1'b0;
      r_fetch_fault    <= 1'b0;
      r_fetch_from_mem <= 1'b0;
    end else begin
      r_fetch_valid <= w_fetch;
      r_fetch_fault <= w_fetch && !w_fetch_hit;
      if (w_fetch) begin
        r_fetch_from_mem <= w_fetch_hit;
      end
    end
  end

  // RAM read data holds between hits, so the selected value holds too
  assign o_fetch_data  = r_fetch_from_mem ? w_rdata : '0;
  assign o_fetch_valid = r_fetch_valid;
  assign o_fetch_fault = r_fetch_fault;
  assign o_load_ready  = r_load_ready;
  assign o_cpu_run     = r_cpu_run;
  assign o_load_count  = r_load_count;
  assign o_checksum    = r_checksum;
  assign o_load_error  = r_load_error;

endmodule : prog_mem_loader
`default_nettype wire
